// File: rtl/ir_axi_lite_slave_regs.sv
// ir_axi_lite_slave_regs
//   AXI4-Lite slave register file for the IR peripheral. It holds four 32-bit
//   read/write control registers (carrier, timing, command, mode) that drive the
//   IR core directly. Every access is answered with OKAY.
//
//   Write path: the address and data beats are latched independently, in either
//   order and with any gap between them. The register is updated on the first
//   edge at which both beats are held. Only one write response can be
//   outstanding, and no new beats are accepted while BVALID is high.
//
//   Read path: the register is sampled on the AR handshake edge. RDATA is held
//   stable until the R handshake.
//
//   The write and read paths run concurrently.
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESETN       clock and asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*  write address, data and response channels
//   S_AXI_AR* / S_AXI_R*             read address and data channels
//   reg0..reg3                       current register values, to the IR core
//   reg_wr_pulse                     one-cycle pulse; bit k = register k was written
module ir_axi_lite_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3,
  output logic [3:0]                      reg_wr_pulse
);

  localparam int NB = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic                          aw_held;
  logic                          w_held;
  logic [1:0]                    aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_hold;
  logic [NB-1:0]                 wstrb_hold;
  logic                          bvalid;
  logic                          rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;
  logic [3:0]                    wr_pulse;
  logic                          commit;

  // Protection bits and the byte-offset address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_AWREADY = !aw_held && !bvalid;
  assign S_AXI_WREADY  = !w_held && !bvalid;
  assign S_AXI_ARREADY = !rvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign reg0          = regs[0];
  assign reg1          = regs[1];
  assign reg2          = regs[2];
  assign reg3          = regs[3];
  assign reg_wr_pulse  = wr_pulse;

  // Both beats are held. BVALID is necessarily low at this point, because the
  // beats can only be accepted while no response is pending.
  assign commit = aw_held && w_held;

  // Write channel: beat capture, commit and response.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_idx     <= 2'd0;
      wdata_hold <= '0;
      wstrb_hold <= '0;
      bvalid     <= 1'b0;
      wr_pulse   <= 4'd0;
      for (int k = 0; k < 4; k++) begin
        regs[k] <= '0;
      end
    end else begin
      wr_pulse <= 4'd0;
      if (commit) begin
        for (int b = 0; b < NB; b++) begin
          if (wstrb_hold[b]) begin
            regs[aw_idx][8*b +: 8] <= wdata_hold[8*b +: 8];
          end
        end
        if (|wstrb_hold) begin
          wr_pulse <= 4'b0001 << aw_idx;
        end
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
      end else begin
        if (S_AXI_AWVALID && S_AXI_AWREADY) begin
          aw_held <= 1'b1;
          aw_idx  <= S_AXI_AWADDR[3:2];
        end
        if (S_AXI_WVALID && S_AXI_WREADY) begin
          w_held     <= 1'b1;
          wdata_hold <= S_AXI_WDATA;
          wstrb_hold <= S_AXI_WSTRB;
        end
        if (bvalid && S_AXI_BREADY) begin
          bvalid <= 1'b0;
        end
      end
    end
  end

  // Read channel. The register is sampled with its pre-edge value, so a read
  // that coincides with a commit to the same register returns the old contents.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        rdata  <= regs[S_AXI_ARADDR[3:2]];
        rvalid <= 1'b1;
      end else if (rvalid && S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ir_axi_lite_slave_regs.sv
module tb_ir_axi_lite_slave_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  reg_wr_pulse;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [4];

  always #5 clk = ~clk;

  ir_axi_lite_slave_regs dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg_wr_pulse(reg_wr_pulse)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_reg0"}, reg0, model[0]);
    chk({tag, "_reg1"}, reg1, model[1]);
    chk({tag, "_reg2"}, reg2, model[2]);
    chk({tag, "_reg3"}, reg3, model[3]);
  endtask

  // Reference behaviour of a write: only the strobed byte lanes of the
  // addressed register change.
  task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input logic [3:0] exp_pulse);
    bit aw_pend = 1'b1;
    bit w_pend = 1'b1;
    bit aw_hs;
    bit w_hs;
    int cyc = 0;
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    while ((aw_pend || w_pend) && cyc < 100) begin
      awvalid = aw_pend && (cyc >= aw_dly);
      wvalid  = w_pend && (cyc >= w_dly);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      step();
      if (aw_hs) aw_pend = 1'b0;
      if (w_hs) w_pend = 1'b0;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("wr_handshake_timeout", {30'd0, aw_pend, w_pend}, 32'd0);
    bready = 1'b1;
    cyc = 0;
    while (!bvalid && cyc < 20) begin
      step();
      cyc++;
    end
    chk("wr_bvalid", bvalid, 1);
    chk("wr_pulse", reg_wr_pulse, exp_pulse);
    chk("wr_bresp", bresp, 0);
    step();
    bready = 1'b0;
    chk("wr_bvalid_clr", bvalid, 0);
    model_write(addr, data, strb);
    $display("WRITE addr=%h data=%h strb=%b pulse_exp=%b", addr, data, strb, exp_pulse);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    bit hs = 1'b0;
    int cyc = 0;
    araddr  = addr;
    arvalid = 1'b1;
    rready  = 1'b1;
    while (!hs && cyc < 50) begin
      hs = arready;
      step();
      cyc++;
    end
    arvalid = 1'b0;
    chk("rd_rvalid", rvalid, 1);
    chk("rd_rresp", rresp, 0);
    data = rdata;
    step();
    rready = 1'b0;
    chk("rd_rvalid_clr", rvalid, 0);
    $display("READ  addr=%h data=%h", addr, data);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic [3:0]  exp_pulse;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] rd;
    logic [31:0] old;
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  s;

    vecs[0] = '{8'h00, 32'h0101FFFF, 4'hF, 32'h0101FFFF, 4'b0001};
    vecs[1] = '{8'h04, 32'hABCD0001, 4'hF, 32'hABCD0001, 4'b0010};
    vecs[2] = '{8'h08, 32'hDEAD0011, 4'hF, 32'hDEAD0011, 4'b0100};
    vecs[3] = '{8'h0C, 32'hBEEF0011, 4'hF, 32'hBEEF0011, 4'b1000};
    vecs[4] = '{8'h04, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF, 4'b0010};
    vecs[5] = '{8'h04, 32'h12345678, 4'h5, 32'hFF34FF78, 4'b0010};
    vecs[6] = '{8'h04, 32'h00000000, 4'h0, 32'hFF34FF78, 4'b0000};
    vecs[7] = '{8'h14, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5, 4'b0010};
    for (int k = 0; k < 4; k++) model[k] = '0;

    // Reset state
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_pulse", reg_wr_pulse, 0);
    chk_regs("rst");

    // Table-driven write/readback vectors
    for (int i = 0; i < 8; i++) begin
      axi_write(vecs[i].addr[3:0], vecs[i].wdata, vecs[i].strb, 0, 0, vecs[i].exp_pulse);
      axi_read(vecs[i].addr[3:0], rd);
      chk($sformatf("tbl%0d_rd", i), rd, vecs[i].exp_rd);
      chk_regs($sformatf("tbl%0d", i));
    end

    // W three cycles ahead of AW
    wdata = 32'h13579BDF; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("wfirst_wready", wready, 0);
    chk("wfirst_awready", awready, 1);
    repeat (2) begin
      step();
      chk("wfirst_bvalid_wait", bvalid, 0);
    end
    awaddr = 4'h8; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("wfirst_bvalid_N", bvalid, 0);
    chk("wfirst_awready_held", awready, 0);
    step();
    chk("wfirst_bvalid_N1", bvalid, 1);
    chk("wfirst_pulse", reg_wr_pulse, 4'b0100);
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("wfirst_bvalid_clr", bvalid, 0);
    chk("wfirst_pulse_clr", reg_wr_pulse, 0);
    model_write(4'h8, 32'h13579BDF, 4'hF);
    chk_regs("wfirst");
    $display("SEQ   w-before-aw done");

    // AW three cycles ahead of W
    awaddr = 4'hC; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("awfirst_awready", awready, 0);
    chk("awfirst_wready", wready, 1);
    repeat (2) begin
      step();
      chk("awfirst_bvalid_wait", bvalid, 0);
    end
    wdata = 32'h2468ACE0; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("awfirst_bvalid_N", bvalid, 0);
    step();
    chk("awfirst_bvalid_N1", bvalid, 1);
    chk("awfirst_pulse", reg_wr_pulse, 4'b1000);
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("awfirst_bvalid_clr", bvalid, 0);
    model_write(4'hC, 32'h2468ACE0, 4'hF);
    chk_regs("awfirst");
    $display("SEQ   aw-before-w done");

    // BREADY held low for 5 cycles
    awaddr = 4'h0; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    repeat (5) begin
      chk("bstall_bvalid", bvalid, 1);
      chk("bstall_awready", awready, 0);
      chk("bstall_wready", wready, 0);
      step();
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("bstall_bvalid_clr", bvalid, 0);
    chk("bstall_awready_back", awready, 1);
    chk("bstall_wready_back", wready, 1);
    model_write(4'h0, 32'hCAFEF00D, 4'hF);
    $display("SEQ   bready stall done");

    // RREADY held low for 5 cycles
    araddr = 4'h0; arvalid = 1'b1; rready = 1'b0;
    step();
    arvalid = 1'b0;
    repeat (5) begin
      chk("rstall_rvalid", rvalid, 1);
      chk("rstall_rdata", rdata, model[0]);
      chk("rstall_arready", arready, 0);
      step();
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("rstall_rvalid_clr", rvalid, 0);
    chk("rstall_arready_back", arready, 1);
    $display("SEQ   rready stall done");

    // A read of reg2 on the edge that commits a write to reg2
    old = model[2];
    awaddr = 4'h8; wdata = 32'h55AA55AA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 4'h8; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("coll_rvalid", rvalid, 1);
    chk("coll_rdata_old", rdata, old);
    chk("coll_bvalid", bvalid, 1);
    model_write(4'h8, 32'h55AA55AA, 4'hF);
    chk("coll_reg2_new", reg2, model[2]);
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    axi_read(4'h8, rd);
    chk("coll_reread", rd, model[2]);
    $display("SEQ   read/commit collision done");

    // Randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom);
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                  (s != 4'd0) ? (4'b0001 << a[3:2]) : 4'd0);
        chk_regs("rnd");
      end else begin
        axi_read(a, rd);
        chk("rnd_rd", rd, model[a[3:2]]);
      end
    end

    // Reset between the AW and W beats
    awaddr = 4'h0; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) model[k] = '0;
    chk("midrst_bvalid", bvalid, 0);
    chk_regs("midrst");
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_awready", awready, 1);
    chk("midrst_wready", wready, 1);
    chk("midrst_arready", arready, 1);
    wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    step();
    step();
    chk("midrst_no_commit", bvalid, 0);
    chk("midrst_reg0", reg0, 0);
    awaddr = 4'h0; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    step();
    chk("midrst_fresh_bvalid", bvalid, 1);
    bready = 1'b1;
    step();
    bready = 1'b0;
    model_write(4'h0, 32'h77777777, 4'hF);
    chk_regs("midrst_after");
    $display("SEQ   mid-transaction reset done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
